// File: rtl/game_input_controller.sv
// ---------------------------------------------------------------------------
// game_input_controller
//
// Purpose:
//   Synchronises and debounces NUM_BUTTONS raw push buttons, resolves them
//   through a fixed lowest-index-wins priority encoder into a one-hot code and
//   queues movement events (press, direction change and, optionally,
//   auto-repeat) in a small first-word-fall-through FIFO read by the CPU over
//   a valid/ready handshake.
//
// Ports:
//   clk          in   single clock
//   reset        in   synchronous, active-high
//   buttons      in   [NUM_BUTTONS]  raw asynchronous buttons, active-high
//   movement     out  [DATA_WIDTH]   registered current winning code, 0 if none
//   evt_valid    out  event queue non-empty
//   evt_data     out  [DATA_WIDTH]   head event code, 0 when empty
//   evt_ready    in   pops the head when evt_valid & evt_ready
//   overflow     out  sticky, set when an event is dropped on a full queue
//   overflow_clr in   clears overflow (a simultaneous drop wins)
//
// Configuration:
//   GAME_INPUT_AUTOREPEAT_EN  defined: held direction re-emits its code
//                             REPEAT_DELAY cycles after the press, then every
//                             REPEAT_RATE cycles.
//                             undefined: events only on press / direction change.
// ---------------------------------------------------------------------------
module game_input_controller #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic [DATA_WIDTH-1:0]  movement,
    output logic                   evt_valid,
    output logic [DATA_WIDTH-1:0]  evt_data,
    input  logic                   evt_ready,
    output logic                   overflow,
    input  logic                   overflow_clr
);

    // Debounce counter only has to hold 0..DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

`ifdef GAME_INPUT_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [RPT_W-1:0] rpt_cnt_r;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1
    } state_t;
`endif

    logic [NUM_BUTTONS-1:0] sync1_r;
    logic [NUM_BUTTONS-1:0] sync2_r;
    logic [NUM_BUTTONS-1:0] deb_r;
    logic [DB_W-1:0]        db_cnt_r [NUM_BUTTONS];

    logic [DATA_WIDTH-1:0]  winner_s;
    logic [DATA_WIDTH-1:0]  prev_r;
    state_t                 state_r;
    logic                   push_s;

    logic [DATA_WIDTH-1:0]  mem_r [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [CW-1:0]          fifo_cnt_r;
    logic                   full_s;
    logic                   do_pop_s;
    logic                   do_push_s;
    logic                   drop_s;

    // Two-flop synchroniser on the raw buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= buttons;
            sync2_r <= sync1_r;
        end
    end

    // Per-button debounce: accept a new level after DEBOUNCE_CYCLES
    // consecutive synced cycles that disagree with the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_r <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_r[i]    <= ~deb_r[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    // Priority encoder: scanning from the top lets the lowest set bit win.
    always_comb begin
        winner_s = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (deb_r[i]) begin
                winner_s = DATA_WIDTH'(1) << i;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Registered level view of the current direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            movement <= '0;
        end else begin
            movement <= winner_s;
        end
    end

    // Event decision for this edge; releases never generate an event.
    always_comb begin
        push_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                push_s = (winner_s != '0);
            end
            ST_DELAY: begin
                if (winner_s == '0) begin
                    push_s = 1'b0;
                end else if (winner_s != prev_r) begin
                    push_s = 1'b1;
`ifdef GAME_INPUT_AUTOREPEAT_EN
                end else if (rpt_cnt_r == RPT_W'(REPEAT_DELAY - 1)) begin
                    push_s = 1'b1;
`endif
                end else begin
                    push_s = 1'b0;
                end
            end
`ifdef GAME_INPUT_AUTOREPEAT_EN
            ST_REPEAT: begin
                if (winner_s == '0) begin
                    push_s = 1'b0;
                end else if (winner_s != prev_r) begin
                    push_s = 1'b1;
                end else if (rpt_cnt_r == RPT_W'(REPEAT_RATE - 1)) begin
                    push_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
`endif
            default: begin
                push_s = 1'b0;
            end
        endcase
    end

    // Event FSM state, last-winner register and repeat timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            prev_r    <= '0;
`ifdef GAME_INPUT_AUTOREPEAT_EN
            rpt_cnt_r <= '0;
`endif
        end else begin
            prev_r <= winner_s;
            case (state_r)
                ST_IDLE: begin
                    if (winner_s != '0) begin
                        state_r   <= ST_DELAY;
`ifdef GAME_INPUT_AUTOREPEAT_EN
                        rpt_cnt_r <= '0;
`endif
                    end
                end
                ST_DELAY: begin
                    if (winner_s == '0) begin
                        state_r <= ST_IDLE;
`ifdef GAME_INPUT_AUTOREPEAT_EN
                    end else if (winner_s != prev_r) begin
                        rpt_cnt_r <= '0;
                    end else if (rpt_cnt_r == RPT_W'(REPEAT_DELAY - 1)) begin
                        rpt_cnt_r <= '0;
                        state_r   <= ST_REPEAT;
                    end else begin
                        rpt_cnt_r <= rpt_cnt_r + RPT_W'(1);
`endif
                    end
                end
`ifdef GAME_INPUT_AUTOREPEAT_EN
                ST_REPEAT: begin
                    if (winner_s == '0) begin
                        state_r <= ST_IDLE;
                    end else if (winner_s != prev_r) begin
                        rpt_cnt_r <= '0;
                        state_r   <= ST_DELAY;
                    end else if (rpt_cnt_r == RPT_W'(REPEAT_RATE - 1)) begin
                        rpt_cnt_r <= '0;
                    end else begin
                        rpt_cnt_r <= rpt_cnt_r + RPT_W'(1);
                    end
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // A pop frees the head slot in the same edge, so a push into a full
    // queue still succeeds when it coincides with a pop.
    assign full_s    = (fifo_cnt_r == CW'(FIFO_DEPTH));
    assign do_pop_s  = evt_valid & evt_ready;
    assign do_push_s = push_s & (~full_s | do_pop_s);
    assign drop_s    = push_s & full_s & ~do_pop_s;
    assign evt_valid = (fifo_cnt_r != CW'(0));
    assign evt_data  = evt_valid ? mem_r[rd_ptr_r] : '0;

    // Event storage; contents are only observable while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= winner_s;
        end
    end

    // Queue pointers, occupancy and sticky overflow flag (set beats clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
            if (drop_s) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_game_input_controller.sv
// ---------------------------------------------------------------------------
// tb_game_input_controller
//
// Directed self-checking bench for game_input_controller with
// DEBOUNCE_CYCLES=4 (press-to-event latency of 7 edges). Inputs are driven
// and outputs sampled 1 time unit after the rising edge. The auto-repeat
// expectations follow GAME_INPUT_AUTOREPEAT_EN as defined for the build.
// ---------------------------------------------------------------------------
module tb_game_input_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  buttons;
    logic [15:0] movement;
    logic        evt_valid;
    logic [15:0] evt_data;
    logic        evt_ready;
    logic        overflow;
    logic        overflow_clr;

    int errors = 0;
    int checks = 0;

    game_input_controller #(
        .NUM_BUTTONS     (4),
        .DATA_WIDTH      (16),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (64),
        .REPEAT_RATE     (16),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .buttons      (buttons),
        .movement     (movement),
        .evt_valid    (evt_valid),
        .evt_data     (evt_data),
        .evt_ready    (evt_ready),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_release(input logic [3:0] b);
        buttons = b;
        step(8);
        buttons = 4'b0000;
        step(8);
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
    endtask

    initial begin
        int n_evt;
        int exp_c;
        int exp_n;
        logic [15:0] exp_q [4];

        reset        = 1'b1;
        buttons      = 4'b0000;
        evt_ready    = 1'b0;
        overflow_clr = 1'b0;
        step(2);
        chk("rst_movement",  movement,  32'h0);
        chk("rst_evt_valid", evt_valid, 32'h0);
        chk("rst_evt_data",  evt_data,  32'h0);
        chk("rst_overflow",  overflow,  32'h0);

        // Single press of right: event appears exactly 7 edges later.
        reset   = 1'b0;
        buttons = 4'b0001;
        step(6);
        chk("press_early_mv",  movement,  32'h0);
        chk("press_early_vld", evt_valid, 32'h0);
        step(1);
        chk("press_mv",   movement,  32'h1);
        chk("press_vld",  evt_valid, 32'h1);
        chk("press_data", evt_data,  32'h1);
        pop_one();
        chk("pop_vld",  evt_valid, 32'h0);
        chk("pop_data", evt_data,  32'h0);
        buttons = 4'b0000;
        step(8);
        chk("release_mv",  movement,  32'h0);
        chk("release_vld", evt_valid, 32'h0);

        // Three-cycle glitch on left is rejected.
        buttons = 4'b0010;
        step(3);
        buttons = 4'b0000;
        step(10);
        chk("glitch_mv",  movement,  32'h0);
        chk("glitch_vld", evt_valid, 32'h0);

        // Right+up together: right wins; releasing right hands over to up.
        buttons = 4'b1001;
        step(7);
        chk("combo_mv",   movement, 32'h1);
        chk("combo_data", evt_data, 32'h1);
        pop_one();
        chk("combo_one_evt", evt_valid, 32'h0);
        buttons = 4'b1000;
        step(7);
        chk("handover_mv",   movement,  32'h8);
        chk("handover_vld",  evt_valid, 32'h1);
        chk("handover_data", evt_data,  32'h8);
        pop_one();
        buttons = 4'b0000;
        step(8);
        chk("up_rel_mv",  movement,  32'h0);
        chk("up_rel_vld", evt_valid, 32'h0);

        // Hold down for 200 cycles with the reader always ready.
`ifdef GAME_INPUT_AUTOREPEAT_EN
        exp_n = 10;
`else
        exp_n = 1;
`endif
        n_evt     = 0;
        exp_c     = 7;
        buttons   = 4'b0100;
        evt_ready = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            step(1);
            if (evt_valid === 1'b1) begin
                chk("rpt_time", c, exp_c);
                chk("rpt_code", evt_data, 32'h4);
                exp_c = exp_c + ((n_evt == 0) ? 64 : 16);
                n_evt++;
            end
        end
        chk("rpt_count", n_evt, exp_n);
        buttons = 4'b0000;
        step(8);
        evt_ready = 1'b0;
        chk("rpt_drained", evt_valid, 32'h0);

        // Five presses with no reader: four queued, fifth dropped.
        press_release(4'b0001);
        press_release(4'b0010);
        press_release(4'b0100);
        press_release(4'b1000);
        chk("full_no_ovf", overflow, 32'h0);
        chk("full_head",   evt_data, 32'h1);
        press_release(4'b0001);
        chk("ovf_set", overflow, 32'h1);
        exp_q = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
        for (int k = 0; k < 4; k++) begin
            chk("ovf_order", evt_data, {16'h0, exp_q[k]});
            pop_one();
        end
        chk("ovf_empty",  evt_valid, 32'h0);
        chk("ovf_sticky", overflow,  32'h1);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        chk("ovf_clr", overflow, 32'h0);

        // Push and pop on the same edge while full: both succeed.
        press_release(4'b0001);
        press_release(4'b0010);
        press_release(4'b0100);
        press_release(4'b1000);
        buttons = 4'b0010;
        step(6);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        chk("pp_no_ovf", overflow,  32'h0);
        chk("pp_vld",    evt_valid, 32'h1);
        buttons = 4'b0000;
        step(8);
        exp_q = '{16'h0002, 16'h0004, 16'h0008, 16'h0002};
        for (int k = 0; k < 4; k++) begin
            chk("pp_order", evt_data, {16'h0, exp_q[k]});
            pop_one();
        end
        chk("pp_empty", evt_valid, 32'h0);

        // Reset while holding right with two events queued.
        buttons = 4'b1000;
        step(8);
        buttons = 4'b1001;
        step(8);
        chk("pre_rst_data", evt_data, 32'h8);
        reset = 1'b1;
        step(1);
        chk("mid_rst_vld", evt_valid, 32'h0);
        chk("mid_rst_mv",  movement,  32'h0);
        reset = 1'b0;
        step(6);
        chk("requal_early", evt_valid, 32'h0);
        step(1);
        chk("requal_vld",  evt_valid, 32'h1);
        chk("requal_data", evt_data,  32'h1);
        chk("requal_mv",   movement,  32'h1);
        pop_one();
        chk("requal_single", evt_valid, 32'h0);
        buttons = 4'b0000;
        step(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
